valu_pipe: RTL

- Parametrised, pipelined, multi-lane successor to the single-lane combinational vector ALU.
- Accepts one vector beat per cycle: LANES elements of DATA_W bits, with a valid/ready handshake on both sides.
- Fixed two-cycle latency. Adds .vx scalar broadcast, extra integer ops and per-lane masking.
- Sits between the vector register file read ports and the output FIFO queue; it carries the VRF destination address alongside each result beat.

---
 rtl/valu_pkg.sv | 49 ++++
 rtl/valu_if.sv | 31 +++
 rtl/valu_lane.sv | 33 +++
 rtl/valu_pipe.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/valu_pkg.sv
// Shared definitions for the pipelined vector ALU: op codes, op classes and decode helpers.
package valu_pkg;

   localparam logic [8:0] OP_ADD_VV  = 9'h000;
   localparam logic [8:0] OP_ADD_VX  = 9'h004;
   localparam logic [8:0] OP_SUB_VV  = 9'h008;
   localparam logic [8:0] OP_SUB_VX  = 9'h00C;
   localparam logic [8:0] OP_MINU_VV = 9'h010;
   localparam logic [8:0] OP_MAXU_VV = 9'h018;
   localparam logic [8:0] OP_AND_VV  = 9'h024;
   localparam logic [8:0] OP_OR_VV   = 9'h028;
   localparam logic [8:0] OP_XOR_VV  = 9'h02C;
   localparam logic [8:0] OP_MUL_VV  = 9'h0B8;
   localparam logic [8:0] OP_MUL_VX  = 9'h0BC;

   // Filler for inactive lanes; the top truncates it to its element width.
   localparam logic [63:0] SENTINEL_DEF = 64'h0000_0000_DEAD_DEAD;

   typedef enum logic [3:0] {
      ADD,
      SUB,
      AND,
      OR,
      XOR,
      MINU,
      MAXU,
      MUL,
      INVALID
   } op_class_e;

   function automatic logic is_vx(input logic [8:0] op);
      return (op == OP_ADD_VX) || (op == OP_SUB_VX) || (op == OP_MUL_VX);
   endfunction

   function automatic op_class_e decode_op(input logic [8:0] op);
      case (op)
         OP_ADD_VV, OP_ADD_VX: return ADD;
         OP_SUB_VV, OP_SUB_VX: return SUB;
         OP_AND_VV:            return AND;
         OP_OR_VV:             return OR;
         OP_XOR_VV:            return XOR;
         OP_MINU_VV:           return MINU;
         OP_MAXU_VV:           return MAXU;
         OP_MUL_VV, OP_MUL_VX: return MUL;
         default:              return INVALID;
      endcase
   endfunction

endpackage

// File: rtl/valu_if.sv
// Beat-level bus of the vector ALU: input beat handshake on one side, result beat handshake on the other.
interface valu_if #(
   parameter int DATA_W = 32,
   parameter int LANES  = 4,
   parameter int ADDR_W = 8
);
   logic                      valu_en;
   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*DATA_W-1:0]   inA;
   logic [LANES*DATA_W-1:0]   inB;
   logic [LANES-1:0]          lane_mask;
   logic [8:0]                op;
   logic [ADDR_W-1:0]         vrfb_addr;
   logic [LANES*DATA_W-1:0]   out_res;
   logic [LANES-1:0]          out_mask;
   logic [ADDR_W-1:0]         vrfo_addr;
   logic                      op_err;
   logic                      valid_out;
   logic                      out_ready;

   modport master (
      output valu_en, in_valid, inA, inB, lane_mask, op, vrfb_addr, out_ready,
      input  in_ready, out_res, out_mask, vrfo_addr, op_err, valid_out
   );

   modport slave (
      input  valu_en, in_valid, inA, inB, lane_mask, op, vrfb_addr, out_ready,
      output in_ready, out_res, out_mask, vrfo_addr, op_err, valid_out
   );
endinterface

// File: rtl/valu_lane.sv
// One combinational ALU lane; unsigned modulo arithmetic, sentinel filler when the lane is inactive.
module valu_lane
   import valu_pkg::*;
#(
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] SENT   = '0
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  op_class_e         op_class,
   input  logic              active,
   output logic [DATA_W-1:0] res,
   output logic              active_out
);
   logic [DATA_W-1:0] raw;

   always_comb begin
      raw = '0;
      case (op_class)
         ADD:     raw = a + b;
         SUB:     raw = a - b;
         AND:     raw = a & b;
         OR:      raw = a | b;
         XOR:     raw = a ^ b;
         MINU:    raw = (a < b) ? a : b;
         MAXU:    raw = (a > b) ? a : b;
         MUL:     raw = a * b;
         default: raw = '0;
      endcase
      active_out = active && (op_class != INVALID);
      res        = active_out ? raw : SENT;
   end
endmodule

// File: rtl/valu_pipe.sv
// Two-stage pipelined multi-lane vector ALU with valid/ready on both sides and VRF address passthrough.
module valu_pipe
   import valu_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter int          LANES    = 4,
   parameter int          ADDR_W   = 8,
   parameter logic [63:0] SENTINEL = SENTINEL_DEF
) (
   input  logic   clk,
   input  logic   nrst,
   valu_if.slave  bus
);
   localparam int                VEC_W = LANES * DATA_W;
   localparam logic [DATA_W-1:0] SENT  = SENTINEL[DATA_W-1:0];

   logic              s1_adv;
   logic              s2_adv;
   logic              in_rdy;
   logic              accept;
   logic              vx_in;
   op_class_e         cls_in;
   logic [VEC_W-1:0]  b_in;

   logic              vld_p1_q, vld_p1_d;
   logic [VEC_W-1:0]  a_p1_q, a_p1_d;
   logic [VEC_W-1:0]  b_p1_q, b_p1_d;
   logic [LANES-1:0]  mask_p1_q, mask_p1_d;
   op_class_e         cls_p1_q, cls_p1_d;
   logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;

   logic [LANES-1:0]  act_in;
   logic [VEC_W-1:0]  lane_res;
   logic [LANES-1:0]  lane_act;

   logic              vld_p2_q, vld_p2_d;
   logic [VEC_W-1:0]  res_p2_q, res_p2_d;
   logic [LANES-1:0]  mask_p2_q, mask_p2_d;
   logic [ADDR_W-1:0] addr_p2_q, addr_p2_d;
   logic              err_p2_q, err_p2_d;

   assign vx_in  = is_vx(bus.op);
   assign cls_in = decode_op(bus.op);

   // Stage 0 -> S1: .vx ops broadcast B lane 0 before capture so S1 only ever holds per-lane operands.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [DATA_W-1:0] a_l;
      logic [DATA_W-1:0] b_l;

      assign b_in[i*DATA_W +: DATA_W] = vx_in ? bus.inB[DATA_W-1:0] : bus.inB[i*DATA_W +: DATA_W];
      assign a_l       = a_p1_q[i*DATA_W +: DATA_W];
      assign b_l       = b_p1_q[i*DATA_W +: DATA_W];
      assign act_in[i] = mask_p1_q[i] && (a_l != SENT) && (b_l != SENT);

      valu_lane #(
         .DATA_W (DATA_W),
         .SENT   (SENT)
      ) u_lane (
         .a          (a_l),
         .b          (b_l),
         .op_class   (cls_p1_q),
         .active     (act_in[i]),
         .res        (lane_res[i*DATA_W +: DATA_W]),
         .active_out (lane_act[i])
      );
   end

   always_comb begin
      s2_adv = !vld_p2_q || bus.out_ready;
      s1_adv = !vld_p1_q || s2_adv;
      // Holding in_ready low during reset keeps the upstream from seeing a phantom accept.
      in_rdy = nrst && bus.valu_en && s1_adv;
      accept = bus.in_valid && in_rdy;

      vld_p1_d  = vld_p1_q;
      a_p1_d    = a_p1_q;
      b_p1_d    = b_p1_q;
      mask_p1_d = mask_p1_q;
      cls_p1_d  = cls_p1_q;
      addr_p1_d = addr_p1_q;
      if (s1_adv) begin
         vld_p1_d = accept;
      end
      if (accept) begin
         a_p1_d    = bus.inA;
         b_p1_d    = b_in;
         mask_p1_d = bus.lane_mask;
         cls_p1_d  = cls_in;
         addr_p1_d = bus.vrfb_addr;
      end

      vld_p2_d  = vld_p2_q;
      res_p2_d  = res_p2_q;
      mask_p2_d = mask_p2_q;
      addr_p2_d = addr_p2_q;
      err_p2_d  = err_p2_q;
      if (s2_adv) begin
         vld_p2_d = vld_p1_q;
      end
      if (s2_adv && vld_p1_q) begin
         res_p2_d  = lane_res;
         mask_p2_d = lane_act;
         addr_p2_d = addr_p1_q;
         err_p2_d  = (cls_p1_q == INVALID);
      end
   end

   // S1 boundary: operand storage, qualified by vld_p1_q.
   always_ff @(posedge clk) begin
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      mask_p1_q <= mask_p1_d;
      cls_p1_q  <= cls_p1_d;
      addr_p1_q <= addr_p1_d;
   end

   // S2 boundary: result registers drive the outputs directly, so they reset to zero.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         res_p2_q  <= '0;
         mask_p2_q <= '0;
         addr_p2_q <= '0;
         err_p2_q  <= 1'b0;
      end else begin
         vld_p1_q  <= vld_p1_d;
         vld_p2_q  <= vld_p2_d;
         res_p2_q  <= res_p2_d;
         mask_p2_q <= mask_p2_d;
         addr_p2_q <= addr_p2_d;
         err_p2_q  <= err_p2_d;
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.valid_out = vld_p2_q;
   assign bus.out_res   = res_p2_q;
   assign bus.out_mask  = mask_p2_q;
   assign bus.vrfo_addr = addr_p2_q;
   assign bus.op_err    = err_p2_q;
endmodule
